// File: rtl/fetch_pc_gen.sv
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : IF-stage PC generator with branch/flush redirect and a one-entry
//            pending-redirect buffer. Optional macro PC_ALIGN_CHECK_EN adds
//            a pc_misalign output that also suppresses rom_en.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  rom_ready,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  rom_en,
    output logic                  pending_valid
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                  pc_misalign
`endif
);

    typedef enum logic [0:0] {
        ST_BOOT  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pending_addr;
    logic [ADDR_WIDTH-1:0] w_pending_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic                  w_pending_valid_nxt;
    logic                  w_advance;
    logic                  w_rom_en_nxt;

    assign w_advance = ~stall & rom_ready;

    always_comb begin
        w_state_nxt         = r_state;
        w_pc_nxt            = pc;
        w_pending_valid_nxt = pending_valid;
        w_pending_addr_nxt  = r_pending_addr;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (flush) begin
                    w_pc_nxt            = flush_pc;
                    w_pending_valid_nxt = 1'b0;
                end else if (w_advance) begin
                    if (pending_valid) begin
                        w_pc_nxt            = r_pending_addr;
                        w_pending_valid_nxt = 1'b0;
                    end else if (branch_flag) begin
                        w_pc_nxt = branch_addr;
                    end else begin
                        w_pc_nxt = pc + ADDR_WIDTH'(PC_STEP);
                    end
                end else if (branch_flag && !pending_valid) begin
                    // First redirect seen while held wins; later ones are dropped.
                    w_pending_addr_nxt  = branch_addr;
                    w_pending_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic w_load;
    logic w_misalign_nxt;

    assign w_load         = (r_state == ST_FETCH) & (flush | w_advance);
    assign w_misalign_nxt = w_load ? (w_pc_nxt[1:0] != 2'b00) : pc_misalign;
    assign w_rom_en_nxt   = (w_state_nxt == ST_FETCH) & ~w_misalign_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_misalign <= 1'b0;
        end else begin
            pc_misalign <= w_misalign_nxt;
        end
    end
`else
    assign w_rom_en_nxt = (w_state_nxt == ST_FETCH);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_BOOT;
            pc             <= RESET_PC;
            rom_en         <= 1'b0;
            pending_valid  <= 1'b0;
            r_pending_addr <= '0;
        end else begin
            r_state        <= w_state_nxt;
            pc             <= w_pc_nxt;
            rom_en         <= w_rom_en_nxt;
            pending_valid  <= w_pending_valid_nxt;
            r_pending_addr <= w_pending_addr_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
// ============================================================================
// Module   : tb_fetch_pc_gen
// Brief    : Self-checking bench for fetch_pc_gen against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_gen;

    localparam logic [31:0] C_RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        rom_ready;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] pc;
    logic        rom_en;
    logic        pending_valid;
`ifdef PC_ALIGN_CHECK_EN
    logic        pc_misalign;
`endif

    fetch_pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .rom_ready     (rom_ready),
        .branch_flag   (branch_flag),
        .branch_addr   (branch_addr),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .pc            (pc),
        .rom_en        (rom_en),
        .pending_valid (pending_valid)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .pc_misalign   (pc_misalign)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: fetch address, booted flag, and a redirect queue of depth <= 1
    logic [31:0] m_pc;
    logic        m_fetching;
    logic [31:0] m_pend_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = C_RESET_PC;
        m_fetching = 1'b0;
        m_pend_q.delete();
    endtask

    task automatic model_edge();
        logic go;
        go = !stall && rom_ready;
        if (!m_fetching) begin
            m_fetching = 1'b1;
        end else if (flush) begin
            m_pc = flush_pc;
            m_pend_q.delete();
        end else if (go) begin
            if (m_pend_q.size() != 0) m_pc = m_pend_q.pop_front();
            else if (branch_flag)     m_pc = branch_addr;
            else                      m_pc = m_pc + 32'd4;
        end else if (branch_flag && m_pend_q.size() == 0) begin
            m_pend_q.push_back(branch_addr);
        end
    endtask

    task automatic check_model(input string where);
        check_eq({where, ".pc"}, pc, m_pc);
        check_eq({where, ".rom_en"}, 32'(rom_en), 32'(m_fetching));
        check_eq({where, ".pending_valid"}, 32'(pending_valid), 32'(m_pend_q.size() != 0));
    endtask

    task automatic step(input string where);
        @(posedge clk);
        model_edge();
        #1;
        check_model(where);
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        rom_ready   = 1'b1;
        branch_flag = 1'b0;
        branch_addr = '0;
        flush       = 1'b0;
        flush_pc    = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #12;
        rst = 1'b0;
        #1;
        check_eq("reset.pc", pc, C_RESET_PC);
        check_eq("reset.rom_en", 32'(rom_en), 32'd0);
        check_eq("reset.pending_valid", 32'(pending_valid), 32'd0);

        step("boot");
        check_eq("boot.rom_en_on", 32'(rom_en), 32'd1);
        step("seq1");
        step("seq2");
        step("seq3");
        check_eq("seq.pc_c", pc, 32'hBFC0_000C);
        step("seq4");

        // Taken branch while advancing
        branch_flag = 1'b1; branch_addr = 32'hBFC0_0100;
        step("branch");
        check_eq("branch.target", pc, 32'hBFC0_0100);
        branch_flag = 1'b0;

        // Branch captured during stall, applied once stall drops
        stall = 1'b1; branch_flag = 1'b1; branch_addr = 32'h8000_0040;
        step("stall_br");
        branch_flag = 1'b0;
        step("stall_hold1");
        step("stall_hold2");
        check_eq("stall.pending", 32'(pending_valid), 32'd1);
        check_eq("stall.pc_hold", pc, 32'hBFC0_0100);
        stall = 1'b0;
        step("stall_release");
        check_eq("stall.applied", pc, 32'h8000_0040);

        // Second capture is ignored; flush overrides pending
        stall = 1'b1; branch_flag = 1'b1; branch_addr = 32'h8000_0040;
        step("pend_a");
        branch_addr = 32'h1234_5670;
        step("pend_b");
        branch_flag = 1'b0;
        flush = 1'b1; flush_pc = 32'hBFC0_0380;
        step("flush");
        check_eq("flush.pc", pc, 32'hBFC0_0380);
        check_eq("flush.pending", 32'(pending_valid), 32'd0);
        flush = 1'b0; stall = 1'b0;

        // Wrap-around with ROM wait
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        step("wrap_load");
        flush = 1'b0; rom_ready = 1'b0;
        step("wrap_wait1");
        step("wrap_wait2");
        check_eq("wrap.hold", pc, 32'hFFFF_FFFC);
        rom_ready = 1'b1;
        step("wrap");
        check_eq("wrap.zero", pc, 32'h0000_0000);

        // Randomized phase
        for (int i = 0; i < 300; i++) begin
            stall       = ($urandom_range(0, 9) < 3);
            rom_ready   = ($urandom_range(0, 9) < 8);
            branch_flag = ($urandom_range(0, 9) < 3);
            branch_addr = $urandom() & 32'hFFFF_FFFC;
            flush       = ($urandom_range(0, 19) == 0);
            flush_pc    = $urandom() & 32'hFFFF_FFFC;
            step("rand");
        end
        idle_inputs();

        // Asynchronous reset with a redirect pending
        stall = 1'b1; branch_flag = 1'b1; branch_addr = 32'h8000_0040;
        step("ar_pend");
        branch_flag = 1'b0;
        check_eq("ar.pending_set", 32'(pending_valid), 32'd1);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("ar.pc", pc, C_RESET_PC);
        check_eq("ar.pending_valid", 32'(pending_valid), 32'd0);
        check_eq("ar.rom_en", 32'(rom_en), 32'd0);
        #2;
        rst = 1'b0;
        stall = 1'b0;
        step("ar_boot");
        step("ar_seq");
        check_eq("ar.after", pc, 32'hBFC0_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
